pending_encoder: RTL and testbench

- Inverse of the team's 2-to-4 one-hot decoder. Collects one-hot/multi-hot event requests on N lines and returns a queue of binary indices, one per request.
- Bit k of the request vector maps to code k, the same mapping the decoder uses, so a decoder downstream reproduces the original line.
- Pending requests are stored in a register. Indices are issued one at a time over a valid/ready handshake.
- Sits between interrupt/event sources and a consumer that handles one index per transaction.

---
 rtl/pending_encoder_pkg.sv | 30 +++
 rtl/pe_pick.sv | 38 +++
 rtl/pending_encoder.sv | 86 ++++++++
 tb/tb_pending_encoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pending_encoder_pkg.sv
// Shared definitions for the pending-request encoder.
// Contents:
//   MAX_N      - widest request vector the encoder supports
//   POL_FIXED  - selection policy: lowest pending index wins
//   POL_RR     - selection policy: round-robin after the last issued index
//   clog2()    - index width for a given number of request lines
//   onehot()   - index -> line mapping, identical to the 2-to-4 decoder's
package pending_encoder_pkg;

  localparam int MAX_N     = 16;
  localparam int POL_FIXED = 0;
  localparam int POL_RR    = 1;

  // Number of bits needed to address 'value' distinct lines.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Bit k of the result is set for index k, so a downstream decoder
  // reproduces the original request line.
  function automatic logic [MAX_N-1:0] onehot(input logic [3:0] idx);
    logic [MAX_N-1:0] one;
    one = 1;
    return one << idx;
  endfunction

endpackage

// File: rtl/pe_pick.sv
// Combinational selector for the pending-request encoder.
// Ports:
//   pending - registered pending-request vector
//   ptr     - last issued index (only used by the round-robin policy)
//   any     - at least one request is pending
//   idx     - index chosen for issue
// The vector is rotated so the search always starts at bit 0, the lowest
// set bit is found, and the rotation is undone on the resulting index.
module pe_pick
  import pending_encoder_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int RR = POL_FIXED
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  logic [W-1:0] start;
  logic [N-1:0] rotated;
  logic [W-1:0] offset;

  // N is a power of two, so W-bit additions wrap modulo N for free.
  always_comb begin
    start   = (RR == POL_RR) ? W'(ptr + 1'b1) : '0;
    rotated = N'({pending, pending} >> start);
    offset  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) offset = W'(i);
    end
    any = |pending;
    idx = offset + start;
  end

endmodule

// File: rtl/pending_encoder.sv
// Pending-request encoder: collects multi-hot requests on N lines and
// issues their binary indices one at a time over a valid/ready handshake.
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   in, en     - request lines, captured each cycle while en=1
//   out        - issued index
//   out_valid  - out holds a valid index
//   out_ready  - consumer accepts out this cycle
//   pending    - registered pending-request vector
//   dropped    - one-cycle pulse when a request merged into a pending line
module pending_encoder
  import pending_encoder_pkg::*;
#(
  parameter int N  = 4,
  parameter int RR = POL_FIXED,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         en,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         dropped
);

  logic [W-1:0]     ptr;
  logic             pick_any;
  logic [W-1:0]     pick_idx;
  logic             load;
  logic [MAX_N-1:0] clr_full;
  logic [N-1:0]     clr;
  logic [N-1:0]     captured;
  logic [N-1:0]     pending_next;
  logic             dropped_next;

  pe_pick #(
    .N  (N),
    .W  (W),
    .RR (RR)
  ) u_pick (
    .pending (pending),
    .ptr     (ptr),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  // A line is cleared when its index is loaded into the output register,
  // not when it is accepted, so an index can never be issued twice. A new
  // request on the line being cleared is OR-ed back in and stays pending.
  always_comb begin
    load         = !out_valid || out_ready;
    clr_full     = onehot(4'(pick_idx));
    clr          = (load && pick_any) ? clr_full[N-1:0] : '0;
    captured     = en ? in : '0;
    pending_next = (pending & ~clr) | captured;
    dropped_next = |(captured & pending & ~clr);
  end

  // The round-robin pointer resets to N-1 so that index 0 is searched first.
  // When nothing is pending at load time, out keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      ptr       <= W'(N - 1);
      dropped   <= 1'b0;
    end else begin
      pending <= pending_next;
      dropped <= dropped_next;
      if (load) begin
        if (pick_any) begin
          out       <= pick_idx;
          out_valid <= 1'b1;
          ptr       <= pick_idx;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pending_encoder.sv
// Self-checking bench for pending_encoder (N=4): one fixed-priority and
// one round-robin instance share the same stimulus and are compared each
// cycle against a behavioural model, plus directed expectations.
module tb_pending_encoder;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       en;
  logic       rdy;

  logic [1:0] out_f, out_r;
  logic       valid_f, valid_r;
  logic [3:0] pend_f, pend_r;
  logic       drop_f, drop_r;

  int n_checks;
  int n_fail;
  int issued;

  // Model state, index 0 = fixed priority, index 1 = round-robin.
  logic [3:0] m_pend [2];
  int         m_out  [2];
  int         m_ptr  [2];
  bit         m_valid[2];
  bit         m_drop [2];

  pending_encoder #(.N(4), .RR(0)) dut_fix (
    .clk(clk), .rst(rst), .in(req), .en(en),
    .out(out_f), .out_valid(valid_f), .out_ready(rdy),
    .pending(pend_f), .dropped(drop_f)
  );

  pending_encoder #(.N(4), .RR(1)) dut_rr (
    .clk(clk), .rst(rst), .in(req), .en(en),
    .out(out_r), .out_valid(valid_r), .out_ready(rdy),
    .pending(pend_r), .dropped(drop_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p]  = 4'b0000;
      m_out[p]   = 0;
      m_ptr[p]   = 3;
      m_valid[p] = 1'b0;
      m_drop[p]  = 1'b0;
    end
  endtask

  // One clock edge of the encoder's rules for policy p, using the inputs
  // that were present just before the edge.
  task automatic modelStep(input int p);
    bit         ld;
    int         sel;
    int         cand;
    logic [3:0] clr;
    logic [3:0] cap;
    ld  = !m_valid[p] || rdy;
    sel = -1;
    if (ld && m_pend[p] != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        cand = (p == 1) ? (m_ptr[p] + k) % 4 : k - 1;
        if (sel < 0 && m_pend[p][cand]) sel = cand;
      end
    end
    clr       = (sel >= 0) ? 4'(1 << sel) : 4'b0000;
    cap       = en ? req : 4'b0000;
    m_drop[p] = (cap & m_pend[p] & ~clr) != 4'b0000;
    m_pend[p] = (m_pend[p] & ~clr) | cap;
    if (ld) begin
      if (sel >= 0) begin
        m_out[p]   = sel;
        m_valid[p] = 1'b1;
        m_ptr[p]   = sel;
      end else begin
        m_valid[p] = 1'b0;
      end
    end
  endtask

  task automatic compareModel();
    checkOutput("fix.out",     32'(out_f),   32'(m_out[0]));
    checkOutput("fix.valid",   32'(valid_f), 32'(m_valid[0]));
    checkOutput("fix.pending", 32'(pend_f),  32'(m_pend[0]));
    checkOutput("fix.dropped", 32'(drop_f),  32'(m_drop[0]));
    checkOutput("rr.out",      32'(out_r),   32'(m_out[1]));
    checkOutput("rr.valid",    32'(valid_r), 32'(m_valid[1]));
    checkOutput("rr.pending",  32'(pend_r),  32'(m_pend[1]));
    checkOutput("rr.dropped",  32'(drop_r),  32'(m_drop[1]));
  endtask

  // Drive inputs, take one clock edge, advance the model and compare 1ns
  // after the edge.
  task automatic applyStimulus(input logic e, input logic [3:0] r, input logic ready);
    en  = e;
    req = r;
    rdy = ready;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    compareModel();
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ".fix.out"},     32'(out_f),   32'd0);
    checkOutput({tag, ".fix.valid"},   32'(valid_f), 32'd0);
    checkOutput({tag, ".fix.pending"}, 32'(pend_f),  32'd0);
    checkOutput({tag, ".fix.dropped"}, 32'(drop_f),  32'd0);
    checkOutput({tag, ".rr.out"},      32'(out_r),   32'd0);
    checkOutput({tag, ".rr.valid"},    32'(valid_r), 32'd0);
    checkOutput({tag, ".rr.pending"},  32'(pend_r),  32'd0);
    checkOutput({tag, ".rr.dropped"},  32'(drop_r),  32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    en  = 1'b0;
    req = 4'b0000;
    rdy = 1'b0;
    modelReset();
    #12;
    checkZero("reset");
    rst = 1'b0;

    $display("[TB] single request");
    applyStimulus(1'b1, 4'b0100, 1'b1);
    checkOutput("single.pend1", 32'(pend_f), 32'b0100);
    checkOutput("single.valid1", 32'(valid_f), 32'd0);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("single.out2", 32'(out_f), 32'd2);
    checkOutput("single.valid2", 32'(valid_f), 32'd1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("single.valid3", 32'(valid_f), 32'd0);
    checkOutput("single.pend3", 32'(pend_f), 32'd0);

    $display("[TB] multi-hot with backpressure");
    applyStimulus(1'b1, 4'b1011, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("bp.out0", 32'(out_f), 32'd0);
    checkOutput("bp.pend0", 32'(pend_f), 32'b1010);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0);
      checkOutput("bp.stall_out", 32'(out_f), 32'd0);
      checkOutput("bp.stall_valid", 32'(valid_f), 32'd1);
    end
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("bp.out1", 32'(out_f), 32'd1);
    checkOutput("bp.pend1", 32'(pend_f), 32'b1000);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("bp.out3", 32'(out_f), 32'd3);
    checkOutput("bp.pend3", 32'(pend_f), 32'b0000);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 4'b0000, 1'b1);

    $display("[TB] merge and re-pend");
    applyStimulus(1'b1, 4'b0010, 1'b1);
    applyStimulus(1'b1, 4'b0010, 1'b1);
    checkOutput("merge.out", 32'(out_f), 32'd1);
    checkOutput("merge.pend", 32'(pend_f), 32'b0010);
    checkOutput("merge.nodrop", 32'(drop_f), 32'd0);
    applyStimulus(1'b1, 4'b0010, 1'b0);
    checkOutput("merge.drop", 32'(drop_f), 32'd1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("merge.drop_end", 32'(drop_f), 32'd0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 4'b0000, 1'b1);

    $display("[TB] enable gating");
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkOutput("gate.pend", 32'(pend_f), 32'd0);
      checkOutput("gate.valid", 32'(valid_f), 32'd0);
    end
    applyStimulus(1'b1, 4'b1111, 1'b1);
    issued = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1);
      if (valid_f) issued++;
    end
    checkOutput("gate.issued", 32'(issued), 32'd4);

    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, 4'b1100, 1'b0);
    applyStimulus(1'b1, 4'b1100, 1'b0);
    checkOutput("arst.pre_valid", 32'(valid_f), 32'd1);
    checkOutput("arst.pre_pend", 32'(pend_f), 32'b1100);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkZero("arst");
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("arst.post_valid", 32'(valid_f), 32'd0);

    $display("[TB] round-robin wrap");
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    rst = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      applyStimulus(1'b1, 4'b1111, 1'b1);
      if (j >= 2) begin
        checkOutput("rr.seq", 32'(out_r), 32'((j - 2) % 4));
        checkOutput("rr.seq_valid", 32'(valid_r), 32'd1);
      end
    end
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 4'b0000, 1'b1);

    $display("[TB] random traffic");
    for (int c = 0; c < 300; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
